memory_stage: RTL and testbench

//   Pipeline MEM stage plus MEM/WB register; sits directly upstream of writeback.

---
 rtl/memory_stage_if.sv | 41 ++++
 rtl/memory_stage.sv | 122 ++++++++++++
 tb/tb_memory_stage.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// rtl/memory_stage_if.sv - EX-side, data-memory and WB-side signals of the MEM stage
interface memory_stage_if #(
  parameter int DATA_W = 24,
  parameter int REG_W  = 4
) ();
  logic              ex_valid;
  logic [DATA_W-1:0] ex_alu_result;
  logic [DATA_W-1:0] ex_store_data;
  logic              ex_mem_read;
  logic              ex_mem_write;
  logic              ex_writeback_enable;
  logic [REG_W-1:0]  ex_rd;
  logic              stall;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;
  logic              wb_writeback_enable;
  logic              wb_mem_read_enable;
  logic [DATA_W-1:0] wb_mem_read_data;
  logic [DATA_W-1:0] wb_alu_result;
  logic [REG_W-1:0]  wb_rd;

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_writeback_enable, ex_rd, dmem_rdata, dmem_ack,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_writeback_enable, wb_mem_read_enable, wb_mem_read_data,
           wb_alu_result, wb_rd
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_mem_read, ex_mem_write,
           ex_writeback_enable, ex_rd, dmem_rdata, dmem_ack,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_writeback_enable, wb_mem_read_enable, wb_mem_read_data,
           wb_alu_result, wb_rd
  );
endinterface

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - MEM stage with req/ack data-memory access and MEM/WB register
module memory_stage #(
  parameter int DATA_W = 24,
  parameter int REG_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  memory_stage_if.slave   bus
);
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              mem_op;
  logic              stall;
  logic              dmem_req_q;
  logic              dmem_we_q;
  logic [DATA_W-1:0] dmem_addr_q;
  logic [DATA_W-1:0] dmem_wdata_q;
  logic [REG_W-1:0]  rd_q;
  logic              wben_q;
  logic              wb_writeback_enable_q;
  logic              wb_mem_read_enable_q;
  logic [DATA_W-1:0] wb_mem_read_data_q;
  logic [DATA_W-1:0] wb_alu_result_q;
  logic [REG_W-1:0]  wb_rd_q;

  assign mem_op = bus.ex_valid & (bus.ex_mem_read | bus.ex_mem_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (mem_op) state_d = ACCESS;
      ACCESS:  if (bus.dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Gated by rst_n so stall drops the instant reset asserts, even with a mem op presented.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (state_q)
        IDLE:    stall = mem_op;
        ACCESS:  stall = ~bus.dmem_ack;
        default: stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_req_q            <= 1'b0;
      dmem_we_q             <= 1'b0;
      dmem_addr_q           <= '0;
      dmem_wdata_q          <= '0;
      rd_q                  <= '0;
      wben_q                <= 1'b0;
      wb_writeback_enable_q <= 1'b0;
      wb_mem_read_enable_q  <= 1'b0;
      wb_mem_read_data_q    <= '0;
      wb_alu_result_q       <= '0;
      wb_rd_q               <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          wb_mem_read_enable_q <= 1'b0;
          wb_mem_read_data_q   <= '0;
          if (mem_op) begin
            // A read takes priority when both read and write are flagged.
            dmem_req_q            <= 1'b1;
            dmem_we_q             <= ~bus.ex_mem_read;
            dmem_addr_q           <= bus.ex_alu_result;
            dmem_wdata_q          <= bus.ex_store_data;
            rd_q                  <= bus.ex_rd;
            wben_q                <= bus.ex_writeback_enable;
            wb_writeback_enable_q <= 1'b0;
            wb_alu_result_q       <= '0;
            wb_rd_q               <= '0;
          end else if (bus.ex_valid) begin
            wb_writeback_enable_q <= bus.ex_writeback_enable;
            wb_alu_result_q       <= bus.ex_alu_result;
            wb_rd_q               <= bus.ex_rd;
          end else begin
            wb_writeback_enable_q <= 1'b0;
            wb_alu_result_q       <= '0;
            wb_rd_q               <= '0;
          end
        end
        ACCESS: begin
          if (bus.dmem_ack) begin
            dmem_req_q            <= 1'b0;
            wb_writeback_enable_q <= wben_q & ~dmem_we_q;
            wb_mem_read_enable_q  <= ~dmem_we_q;
            wb_mem_read_data_q    <= dmem_we_q ? '0 : bus.dmem_rdata;
            wb_alu_result_q       <= dmem_addr_q;
            wb_rd_q               <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall               = stall;
  assign bus.dmem_req            = dmem_req_q;
  assign bus.dmem_we             = dmem_we_q;
  assign bus.dmem_addr           = dmem_addr_q;
  assign bus.dmem_wdata          = dmem_wdata_q;
  assign bus.wb_writeback_enable = wb_writeback_enable_q;
  assign bus.wb_mem_read_enable  = wb_mem_read_enable_q;
  assign bus.wb_mem_read_data    = wb_mem_read_data_q;
  assign bus.wb_alu_result       = wb_alu_result_q;
  assign bus.wb_rd               = wb_rd_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - random and directed stimulus against a transaction-level model
module tb_memory_stage;
  localparam int DW = 24;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  memory_stage_if #(.DATA_W(DW), .REG_W(RW)) bus ();
  memory_stage #(.DATA_W(DW), .REG_W(RW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // memory responder controls
  int          resp_delay = 0;
  bit          resp_rand  = 1'b0;
  logic [DW-1:0] rdata_fix = '0;
  logic        resp_ack = 1'b0;
  logic        dir_ack  = 1'b0;
  int          resp_cnt = 0;
  assign bus.dmem_ack = resp_ack | dir_ack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    logic [31:0] r;
    bus.dmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        resp_ack = 1'b0;
        resp_cnt = 0;
      end else if (resp_ack) begin
        resp_ack = 1'b0;
      end else if (bus.dmem_req) begin
        if (resp_cnt >= resp_delay) begin
          r = $urandom;
          bus.dmem_rdata = resp_rand ? r[DW-1:0] : rdata_fix;
          resp_ack = 1'b1;
          resp_cnt = 0;
          if (resp_rand) resp_delay = $urandom_range(0, 3);
        end else begin
          resp_cnt++;
        end
      end
    end
  end

  // Model: one outstanding access at most; WB shows what the previous cycle completed.
  bit            m_req = 0, m_we = 0, m_wben = 0;
  logic [DW-1:0] m_addr = '0, m_wdata = '0;
  logic [RW-1:0] m_rd = '0;
  bit            e_wben = 0, e_mre = 0;
  logic [DW-1:0] e_mrd = '0, e_alu = '0;
  logic [RW-1:0] e_rd = '0;
  int            stall_cnt = 0;
  logic [7:0]    req_hist = '0;
  logic [DW-1:0] last_addr = '0, last_wdata = '0;
  logic          last_we = 1'b0;

  always @(negedge clk) begin
    bit mop, exp_stall;
    if (!rst_n) begin
      m_req = 0; e_wben = 0; e_mre = 0; e_mrd = '0; e_alu = '0; e_rd = '0;
    end else begin
      mop = bus.ex_valid && (bus.ex_mem_read || bus.ex_mem_write);
      exp_stall = m_req ? !bus.dmem_ack : mop;
      chk("stall", {31'b0, bus.stall}, {31'b0, exp_stall});
      chk("dmem_req", {31'b0, bus.dmem_req}, {31'b0, m_req});
      if (m_req) begin
        chk("dmem_we", {31'b0, bus.dmem_we}, {31'b0, m_we});
        chk("dmem_addr", {8'b0, bus.dmem_addr}, {8'b0, m_addr});
        if (m_we) chk("dmem_wdata", {8'b0, bus.dmem_wdata}, {8'b0, m_wdata});
      end
      chk("wb_writeback_enable", {31'b0, bus.wb_writeback_enable}, {31'b0, e_wben});
      chk("wb_mem_read_enable", {31'b0, bus.wb_mem_read_enable}, {31'b0, e_mre});
      chk("wb_mem_read_data", {8'b0, bus.wb_mem_read_data}, {8'b0, e_mrd});
      chk("wb_alu_result", {8'b0, bus.wb_alu_result}, {8'b0, e_alu});
      chk("wb_rd", {28'b0, bus.wb_rd}, {28'b0, e_rd});
      if (bus.stall) stall_cnt++;
      req_hist = {req_hist[6:0], bus.dmem_req};
      if (bus.dmem_req) begin
        last_addr = bus.dmem_addr; last_we = bus.dmem_we; last_wdata = bus.dmem_wdata;
      end
      e_wben = 0; e_mre = 0; e_mrd = '0; e_alu = '0; e_rd = '0;
      if (m_req) begin
        if (bus.dmem_ack) begin
          m_req = 0;
          e_alu = m_addr; e_rd = m_rd;
          if (!m_we) begin
            e_mre = 1; e_mrd = bus.dmem_rdata; e_wben = m_wben;
          end
        end
      end else if (mop) begin
        m_req = 1; m_we = !bus.ex_mem_read; m_addr = bus.ex_alu_result;
        m_wdata = bus.ex_store_data; m_rd = bus.ex_rd; m_wben = bus.ex_writeback_enable;
      end else if (bus.ex_valid) begin
        e_wben = bus.ex_writeback_enable; e_alu = bus.ex_alu_result; e_rd = bus.ex_rd;
      end
    end
  end

  task automatic drive(input bit v, input bit rd_, input bit wr_, input bit wen,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sd, input logic [RW-1:0] rdi);
    bus.ex_valid = v; bus.ex_mem_read = rd_; bus.ex_mem_write = wr_;
    bus.ex_writeback_enable = wen; bus.ex_alu_result = alu;
    bus.ex_store_data = sd; bus.ex_rd = rdi;
  endtask

  // Present one instruction (called just after a rising edge), hold it until accepted.
  task automatic issue(input bit v, input bit rd_, input bit wr_, input bit wen,
                       input logic [DW-1:0] alu, input logic [DW-1:0] sd, input logic [RW-1:0] rdi);
    int n = 0;
    drive(v, rd_, wr_, wen, alu, sd, rdi);
    @(negedge clk);
    while (bus.stall) begin
      n++;
      if (n > 64) begin
        chk("issue_timeout", 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int s0;
    logic [31:0] r1, r2;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, '0, '0, '0);
    #2;
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_dmem_addr", {8'b0, bus.dmem_addr}, 32'd0);
    chk("rst_wb_alu_result", {8'b0, bus.wb_alu_result}, 32'd0);
    chk("rst_wb_writeback_enable", {31'b0, bus.wb_writeback_enable}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU op
    s0 = stall_cnt;
    issue(1, 0, 0, 1, 24'h001234, 24'h0, 4'd3);
    chk("t1_wb_alu_result", {8'b0, bus.wb_alu_result}, 32'h001234);
    chk("t1_wb_rd", {28'b0, bus.wb_rd}, 32'd3);
    chk("t1_wb_writeback_enable", {31'b0, bus.wb_writeback_enable}, 32'd1);
    chk("t1_wb_mem_read_enable", {31'b0, bus.wb_mem_read_enable}, 32'd0);
    chk("t1_stall_cycles", stall_cnt - s0, 32'd0);

    // load with ack 3 cycles after req
    resp_delay = 3; rdata_fix = 24'hABCDEF;
    s0 = stall_cnt;
    issue(1, 1, 0, 1, 24'h000040, 24'h0, 4'd7);
    chk("t2_stall_cycles", stall_cnt - s0, 32'd4);
    chk("t2_dmem_addr", {8'b0, last_addr}, 32'h000040);
    chk("t2_dmem_we", {31'b0, last_we}, 32'd0);
    chk("t2_wb_mem_read_enable", {31'b0, bus.wb_mem_read_enable}, 32'd1);
    chk("t2_wb_mem_read_data", {8'b0, bus.wb_mem_read_data}, 32'hABCDEF);
    chk("t2_wb_rd", {28'b0, bus.wb_rd}, 32'd7);

    // store with immediate ack
    resp_delay = 0;
    issue(1, 0, 1, 1, 24'h000010, 24'h5A5A5A, 4'd2);
    chk("t3_dmem_we", {31'b0, last_we}, 32'd1);
    chk("t3_dmem_wdata", {8'b0, last_wdata}, 32'h5A5A5A);
    chk("t3_wb_writeback_enable", {31'b0, bus.wb_writeback_enable}, 32'd0);
    chk("t3_wb_mem_read_enable", {31'b0, bus.wb_mem_read_enable}, 32'd0);

    // back-to-back loads
    drive(0, 0, 0, 0, '0, '0, '0);
    @(posedge clk); #1;
    rdata_fix = 24'h13579B;
    issue(1, 1, 0, 1, 24'h000100, 24'h0, 4'd5);
    chk("t4_first_rd", {28'b0, bus.wb_rd}, 32'd5);
    chk("t4_first_data", {8'b0, bus.wb_mem_read_data}, 32'h13579B);
    issue(1, 1, 0, 1, 24'h000104, 24'h0, 4'd6);
    chk("t4_second_rd", {28'b0, bus.wb_rd}, 32'd6);
    chk("t4_second_alu", {8'b0, bus.wb_alu_result}, 32'h000104);
    chk("t4_req_pattern", {28'b0, req_hist[3:0]}, 32'b0101);

    // reset during ACCESS
    resp_delay = 30;
    drive(1, 1, 0, 1, 24'h000200, 24'h0, 4'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_req_before", {31'b0, bus.dmem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("t5_stall", {31'b0, bus.stall}, 32'd0);
    chk("t5_wb_writeback_enable", {31'b0, bus.wb_writeback_enable}, 32'd0);
    chk("t5_wb_alu_result", {8'b0, bus.wb_alu_result}, 32'd0);
    drive(0, 0, 0, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    resp_delay = 0;
    s0 = stall_cnt;
    issue(1, 0, 0, 1, 24'h00BEEF, 24'h0, 4'd4);
    chk("t5_after_alu", {8'b0, bus.wb_alu_result}, 32'h00BEEF);
    chk("t5_after_stall", stall_cnt - s0, 32'd0);

    // stray ack while idle
    drive(0, 0, 0, 0, '0, '0, '0);
    dir_ack = 1'b1;
    @(posedge clk); #1;
    dir_ack = 1'b0;
    chk("t6_dmem_req", {31'b0, bus.dmem_req}, 32'd0);
    chk("t6_wb_writeback_enable", {31'b0, bus.wb_writeback_enable}, 32'd0);
    chk("t6_wb_mem_read_enable", {31'b0, bus.wb_mem_read_enable}, 32'd0);
    chk("t6_wb_alu_result", {8'b0, bus.wb_alu_result}, 32'd0);

    // random traffic
    resp_rand = 1'b1;
    resp_delay = $urandom_range(0, 3);
    for (int i = 0; i < 400; i++) begin
      int k;
      k = $urandom_range(0, 4);
      r1 = $urandom; r2 = $urandom;
      case (k)
        0: issue(0, r1[24], r1[25], r1[26], r1[DW-1:0], r2[DW-1:0], r2[27:24]);
        1: issue(1, 0, 0, r1[26], r1[DW-1:0], r2[DW-1:0], r2[27:24]);
        2: issue(1, 1, 0, r1[26], r1[DW-1:0], r2[DW-1:0], r2[27:24]);
        3: issue(1, 0, 1, r1[26], r1[DW-1:0], r2[DW-1:0], r2[27:24]);
        default: issue(1, 1, 1, r1[26], r1[DW-1:0], r2[DW-1:0], r2[27:24]);
      endcase
    end
    drive(0, 0, 0, 0, '0, '0, '0);
    repeat (8) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
